// File: rtl/program_loader_if.sv
// Loader-side bundle: UART byte handshake, program-memory write port, phase flags.
// Latency: none, wires only.
// Backpressure: tx_ready throttles tx_valid; the rx and program-memory sides have no stall.
// Ports: start/rx_valid/rx_data/tx_ready flow into the loader (master inputs);
//        tx_*, prog_*, the four *_finished pulses, done and error flow out of it.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_ready;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [31:0]           prog_wdata;
  logic                  transmit_0x99_finished;
  logic                  receive_program_data_size_finished;
  logic                  receive_program_data_finished;
  logic                  transmit_0xAA_finished;
  logic                  done;
  logic                  error;

  // The loader itself.
  modport master (
    input  start, rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, prog_we, prog_addr, prog_wdata,
           transmit_0x99_finished, receive_program_data_size_finished,
           receive_program_data_finished, transmit_0xAA_finished,
           done, error
  );

  // UART, program memory and state controller side.
  modport slave (
    output start, rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, prog_we, prog_addr, prog_wdata,
           transmit_0x99_finished, receive_program_data_size_finished,
           receive_program_data_finished, transmit_0xAA_finished,
           done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: sends 0x99, reads a 4-byte LE size, packs the program into 32-bit words, sends 0xAA.
// Latency: one cycle from rx byte / tx acceptance to the registered write strobe or finished flag.
// Backpressure: tx_valid and tx_data hold until tx_ready; rx bytes are never stalled.
// Ports: clk, reset (synchronous, active high), bus (program_loader_if.master).
module program_loader #(
  parameter int ADDR_WIDTH = 13
) (
  input logic              clk,
  input logic              reset,
  program_loader_if.master bus
);

  // Program memory capacity in bytes, one bit wider so that ADDR_WIDTH=30 still fits.
  localparam logic [32:0] CAPACITY = 33'd4 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SEND_99,
    RECV_SIZE,
    RECV_DATA,
    SEND_AA,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [31:0] size_q;
  logic [31:0] byte_count;
  logic [31:0] word_buf;

  logic [1:0]  lane;
  logic [31:0] count_next;
  logic [31:0] size_next;
  logic [31:0] word_next;
  logic        last_byte;

  assign lane       = byte_count[1:0];
  assign count_next = byte_count + 32'd1;
  // Size bytes arrive LSB first: shifting each new byte in at the top leaves the
  // first one in bits 7:0 after four bytes.
  assign size_next  = {bus.rx_data, size_q[31:8]};
  // word_buf is cleared after every write, so untouched upper lanes of a partial
  // final word are already zero.
  assign word_next  = word_buf | ({24'd0, bus.rx_data} << {lane, 3'b000});
  assign last_byte  = (count_next == size_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                                  <= IDLE;
      size_q                                 <= '0;
      byte_count                             <= '0;
      word_buf                               <= '0;
      bus.tx_valid                           <= 1'b0;
      bus.tx_data                            <= 8'h00;
      bus.prog_we                            <= 1'b0;
      bus.prog_addr                          <= '0;
      bus.prog_wdata                         <= '0;
      bus.transmit_0x99_finished             <= 1'b0;
      bus.receive_program_data_size_finished <= 1'b0;
      bus.receive_program_data_finished      <= 1'b0;
      bus.transmit_0xAA_finished             <= 1'b0;
      bus.done                               <= 1'b0;
      bus.error                              <= 1'b0;
    end else begin
      // Strobes and finished flags are single-cycle unless re-asserted below.
      bus.prog_we                            <= 1'b0;
      bus.transmit_0x99_finished             <= 1'b0;
      bus.receive_program_data_size_finished <= 1'b0;
      bus.receive_program_data_finished      <= 1'b0;
      bus.transmit_0xAA_finished             <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= SEND_99;
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= 8'h99;
          end
        end

        SEND_99: begin
          if (bus.tx_valid && bus.tx_ready) begin
            state                      <= RECV_SIZE;
            bus.tx_valid               <= 1'b0;
            bus.tx_data                <= 8'h00;
            bus.transmit_0x99_finished <= 1'b1;
          end
        end

        RECV_SIZE: begin
          if (bus.rx_valid) begin
            size_q <= size_next;
            if (lane == 2'd3) begin
              // byte_count restarts so RECV_DATA counts data bytes from zero.
              byte_count                             <= '0;
              bus.receive_program_data_size_finished <= 1'b1;
              if (size_next == 32'd0) begin
                state        <= SEND_AA;
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= 8'hAA;
              end else if ({1'b0, size_next} > CAPACITY) begin
                state     <= ERROR;
                bus.error <= 1'b1;
              end else begin
                state <= RECV_DATA;
              end
            end else begin
              byte_count <= count_next;
            end
          end
        end

        RECV_DATA: begin
          if (bus.rx_valid) begin
            byte_count <= count_next;
            if (lane == 2'd3 || last_byte) begin
              bus.prog_we    <= 1'b1;
              bus.prog_addr  <= byte_count[ADDR_WIDTH+1:2];
              bus.prog_wdata <= word_next;
              word_buf       <= '0;
            end else begin
              word_buf <= word_next;
            end
            if (last_byte) begin
              state                             <= SEND_AA;
              bus.receive_program_data_finished <= 1'b1;
              bus.tx_valid                      <= 1'b1;
              bus.tx_data                       <= 8'hAA;
            end
          end
        end

        SEND_AA: begin
          if (bus.tx_valid && bus.tx_ready) begin
            state                      <= DONE;
            bus.tx_valid               <= 1'b0;
            bus.tx_data                <= 8'h00;
            bus.transmit_0xAA_finished <= 1'b1;
            bus.done                   <= 1'b1;
          end
        end

        // Terminal states: only reset leaves them.
        DONE:    ;
        ERROR:   ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  localparam int AW  = 2;
  localparam int CAP = 4 << AW;   // 16 bytes

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();
  program_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_SEND_99, M_RECV_SIZE, M_RECV_DATA, M_SEND_AA, M_DONE, M_ERROR} phase_t;
  phase_t phase = M_IDLE;
  byte unsigned size_bytes[$];
  byte unsigned data_bytes[$];
  longint unsigned m_size = 0;

  logic          m_tx_valid = 1'b0;
  logic [7:0]    m_tx_data  = 8'h00;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic          m_f99 = 1'b0, m_fsize = 1'b0, m_fdata = 1'b0, m_faa = 1'b0;
  logic          m_done = 1'b0, m_error = 1'b0;
  int            mlog_addr[$];
  logic [31:0]   mlog_data[$];

  always @(posedge clk) begin
    int n, w;
    m_we = 1'b0; m_f99 = 1'b0; m_fsize = 1'b0; m_fdata = 1'b0; m_faa = 1'b0;
    if (reset) begin
      phase = M_IDLE;
      size_bytes.delete();
      data_bytes.delete();
      m_addr = '0; m_wdata = '0;
    end else begin
      case (phase)
        M_IDLE:    if (bus.start) phase = M_SEND_99;
        M_SEND_99: if (bus.tx_ready) begin m_f99 = 1'b1; phase = M_RECV_SIZE; end
        M_RECV_SIZE: if (bus.rx_valid) begin
          size_bytes.push_back(bus.rx_data);
          if (size_bytes.size() == 4) begin
            m_size = longint'(size_bytes[0]) + longint'(size_bytes[1]) * 256
                   + longint'(size_bytes[2]) * 65536 + longint'(size_bytes[3]) * 16777216;
            m_fsize = 1'b1;
            if (m_size == 0)        phase = M_SEND_AA;
            else if (m_size > CAP)  phase = M_ERROR;
            else                    phase = M_RECV_DATA;
          end
        end
        M_RECV_DATA: if (bus.rx_valid) begin
          data_bytes.push_back(bus.rx_data);
          n = data_bytes.size();
          if (n % 4 == 0 || n == m_size) begin
            w = (n - 1) / 4;
            m_we = 1'b1;
            m_addr = AW'(w);
            m_wdata = '0;
            for (int k = 4 * w; k < n; k++)
              m_wdata = m_wdata | (32'(data_bytes[k]) << (8 * (k - 4 * w)));
            mlog_addr.push_back(w);
            mlog_data.push_back(m_wdata);
            if (n == m_size) begin m_fdata = 1'b1; phase = M_SEND_AA; end
          end
        end
        M_SEND_AA: if (bus.tx_ready) begin m_faa = 1'b1; phase = M_DONE; end
        default: ;
      endcase
    end
    m_tx_valid = (phase == M_SEND_99) || (phase == M_SEND_AA);
    m_tx_data  = (phase == M_SEND_99) ? 8'h99 : (phase == M_SEND_AA) ? 8'hAA : 8'h00;
    m_done     = (phase == M_DONE);
    m_error    = (phase == M_ERROR);
  end

  // ---------------- per-cycle comparison ----------------
  int           dut_we_cnt = 0;
  byte unsigned tx_log[$];
  logic [AW:0]  fin_snap = '0;   // {prog_we, prog_addr} seen with receive_program_data_finished
  logic [14:0]  got_ctl, exp_ctl;

  always @(negedge clk) begin
    if (chk_en) begin
      got_ctl = {bus.tx_valid, bus.tx_data, bus.prog_we, bus.transmit_0x99_finished,
                 bus.receive_program_data_size_finished, bus.receive_program_data_finished,
                 bus.transmit_0xAA_finished, bus.done, bus.error};
      exp_ctl = {m_tx_valid, m_tx_data, m_we, m_f99, m_fsize, m_fdata, m_faa, m_done, m_error};
      checks++;
      if (got_ctl !== exp_ctl ||
          (m_we && (bus.prog_addr !== m_addr || bus.prog_wdata !== m_wdata))) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t: got ctl=%b addr=%0h wdata=%h expected ctl=%b addr=%0h wdata=%h",
                 $time, got_ctl, bus.prog_addr, bus.prog_wdata, exp_ctl, m_addr, m_wdata);
      end
      if (bus.prog_we) dut_we_cnt++;
      if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
      if (bus.receive_program_data_finished) fin_snap = {bus.prog_we, bus.prog_addr};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    mlog_addr.delete();
    mlog_data.delete();
    dut_we_cnt = 0;
    fin_snap = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (gap) tick();
    end
  endtask

  task automatic send_size(input int unsigned sz, input int gap);
    for (int i = 0; i < 4; i++) send_byte(8'((sz >> (8 * i)) & 32'hFF), gap);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Arithmetic byte sequence first, first+step, ... (8-bit wrap).
  task automatic send_seq(input byte unsigned first, input byte unsigned step, input int n, input int gap);
    byte unsigned b;
    b = first;
    for (int i = 0; i < n; i++) begin
      send_byte(b, gap);
      b = b + step;
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // which=0: wait for transmit_0x99_finished; which=1: wait for done or error.
  task automatic wait_for(input string name, input int which);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = (which == 0) ? bus.transmit_0x99_finished : (bus.done || bus.error);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL timeout_%s: event not seen within 200 cycles, required it", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.tx_valid, bus.tx_data, bus.prog_we, bus.prog_addr, bus.prog_wdata,
                 bus.transmit_0x99_finished, bus.receive_program_data_size_finished,
                 bus.receive_program_data_finished, bus.transmit_0xAA_finished,
                 bus.done, bus.error}, 64'd0);
  endtask

  task automatic begin_load(input int unsigned sz, input int gap);
    pulse_start();
    wait_for("f99", 0);
    send_size(sz, gap);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
    do_reset();
    chk_en = 1'b1;
    check_all_zero("reset_outputs");

    // Nominal: 8 bytes -> two words.
    clear_logs();
    begin_load(8, 1);
    send_seq(8'h11, 8'h11, 8, 1);
    wait_for("nominal_end", 1);
    check("nom_done", bus.done, 1);
    check("nom_we_cnt", dut_we_cnt, 2);
    check("nom_tx_cnt", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("nom_tx0", tx_log[0], 8'h99);
      check("nom_tx1", tx_log[1], 8'hAA);
    end
    check("nom_log_cnt", mlog_addr.size(), 2);
    if (mlog_addr.size() == 2) begin
      check("nom_w0", {mlog_addr[0], mlog_data[0]}, {32'd0, 32'h44332211});
      check("nom_w1", {mlog_addr[1], mlog_data[1]}, {32'd1, 32'h88776655});
    end

    // Size zero: straight to 0xAA.
    do_reset(); clear_logs();
    begin_load(0, 1);
    wait_for("size0_end", 1);
    check("sz0_done", bus.done, 1);
    check("sz0_we_cnt", dut_we_cnt, 0);
    check("sz0_tx_cnt", tx_log.size(), 2);

    // Partial final word.
    do_reset(); clear_logs();
    begin_load(5, 1);
    send_seq(8'hAA, 8'h11, 5, 1);
    wait_for("partial_end", 1);
    check("part_we_cnt", dut_we_cnt, 2);
    check("part_fin_with_we", fin_snap, {1'b1, 2'd1});
    if (mlog_addr.size() == 2) begin
      check("part_w0", mlog_data[0], 32'hDDCCBBAA);
      check("part_w1", mlog_data[1], 32'h000000EE);
    end else check("part_log_cnt", mlog_addr.size(), 2);

    // Oversize: 17 > 16-byte capacity.
    do_reset(); clear_logs();
    begin_load(17, 1);
    wait_for("oversize_end", 1);
    send_seq(8'h01, 8'h01, 6, 0);
    repeat (3) tick();
    check("over_error", bus.error, 1);
    check("over_done", bus.done, 0);
    check("over_we_cnt", dut_we_cnt, 0);
    check("over_tx_cnt", tx_log.size(), 1);
    check("over_tx_valid", bus.tx_valid, 0);

    // Exactly capacity: accepted, last address is the top word.
    do_reset(); clear_logs();
    begin_load(CAP, 0);
    send_seq(8'h01, 8'h01, CAP, 0);
    wait_for("cap_end", 1);
    check("cap_done", bus.done, 1);
    check("cap_we_cnt", dut_we_cnt, 4);
    if (mlog_addr.size() == 4)
      check("cap_w3", {mlog_addr[3], mlog_data[3]}, {32'd3, 32'h100F0E0D});

    // Backpressure on both sends, back-to-back rx.
    do_reset(); clear_logs();
    bus.tx_ready = 1'b0;
    pulse_start();
    repeat (10) tick();
    check("bp_hold99", {bus.tx_valid, bus.tx_data, bus.transmit_0x99_finished}, {1'b1, 8'h99, 1'b0});
    check("bp_no_accept", tx_log.size(), 0);
    bus.tx_ready = 1'b1;
    wait_for("bp_f99", 0);
    send_size(8, 0);
    bus.tx_ready = 1'b0;
    send_seq(8'h01, 8'h01, 8, 0);
    repeat (5) tick();
    check("bp_holdAA", {bus.tx_valid, bus.tx_data, bus.done}, {1'b1, 8'hAA, 1'b0});
    bus.tx_ready = 1'b1;
    wait_for("bp_end", 1);
    check("bp_done", bus.done, 1);
    if (mlog_addr.size() == 2) begin
      check("bp_w0", mlog_data[0], 32'h04030201);
      check("bp_w1", mlog_data[1], 32'h08070605);
    end else check("bp_log_cnt", mlog_addr.size(), 2);

    // Reset mid-load, then a fresh 4-byte load.
    do_reset(); clear_logs();
    begin_load(8, 1);
    send_seq(8'h55, 8'h01, 3, 1);
    do_reset();
    check_all_zero("midreset_outputs");
    clear_logs();
    begin_load(4, 1);
    send_seq(8'h10, 8'h10, 4, 1);
    wait_for("reload_end", 1);
    check("reload_done", bus.done, 1);
    check("reload_we_cnt", dut_we_cnt, 1);
    if (mlog_addr.size() == 1)
      check("reload_w0", {mlog_addr[0], mlog_data[0]}, {32'd0, 32'h40302010});

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
